// File: rtl/led_scan_sequencer_if.sv
// led_scan_sequencer_if -- control/status bundle for the LED scan sequencer.
//   start  : one-cycle request to begin or restart a scan
//   stop   : one-cycle request to end the scan
//   pause  : level, freezes an active scan
//   dir    : start direction (0 = up from 0, 1 = down from 7), sampled on start
//   mode   : 0 = wrap, 1 = bounce, evaluated at every step
//   period : cycles per step minus one, evaluated every cycle
//   switch : LED index for the downstream 3-to-8 decoder
//   enable : decoder enable, 3'b100 = active, 3'b000 = blank
//   busy   : scan active (running or held)
//   step   : pulse with each new switch value
//   lap    : pulse with each wrap or bounce reversal
// master drives the controls; slave (the sequencer) drives the status.
interface led_scan_sequencer_if #(
  parameter int PRESCALE_W = 4
);
  logic                  start;
  logic                  stop;
  logic                  pause;
  logic                  dir;
  logic                  mode;
  logic [PRESCALE_W-1:0] period;
  logic [2:0]            switch;
  logic [2:0]            enable;
  logic                  busy;
  logic                  step;
  logic                  lap;

  modport master (
    output start, stop, pause, dir, mode, period,
    input  switch, enable, busy, step, lap
  );

  modport slave (
    input  start, stop, pause, dir, mode, period,
    output switch, enable, busy, step, lap
  );
endinterface

// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer -- walks a lit LED index across 8 positions.
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : led_scan_sequencer_if.slave (controls in, registered status out)
// A prescaler counts up to 'period'; each time it reaches it the index moves
// one place, wrapping (7<->0) or reversing at the ends (bounce). All outputs
// come straight from flops.
module led_scan_sequencer #(
  parameter int PRESCALE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  led_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b000;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_switch, w_switch_nxt;
  logic                  r_down, w_down_nxt;
  logic [PRESCALE_W-1:0] r_presc, w_presc_nxt;
  logic                  r_step, w_step_nxt;
  logic                  r_lap, w_lap_nxt;
  logic [2:0]            r_enable, w_enable_nxt;
  logic                  r_busy, w_busy_nxt;

  logic [2:0]            w_adv_idx;
  logic                  w_adv_down;
  logic                  w_adv_lap;
  logic                  w_tick;

  // '>=' rather than '==' so a period lowered below the running count
  // still fires on the next cycle instead of rolling all the way round.
  assign w_tick = (r_presc >= bus.period);

  // Index that one advance would produce from the current position.
  always_comb begin
    w_adv_idx  = r_switch;
    w_adv_down = r_down;
    w_adv_lap  = 1'b0;
    if (!r_down) begin
      if (r_switch == 3'd7) begin
        w_adv_lap = 1'b1;
        if (bus.mode) begin
          w_adv_idx  = 3'd6;
          w_adv_down = 1'b1;
        end else begin
          w_adv_idx  = 3'd0;
        end
      end else begin
        w_adv_idx = r_switch + 3'd1;
      end
    end else begin
      if (r_switch == 3'd0) begin
        w_adv_lap = 1'b1;
        if (bus.mode) begin
          w_adv_idx  = 3'd1;
          w_adv_down = 1'b0;
        end else begin
          w_adv_idx  = 3'd7;
        end
      end else begin
        w_adv_idx = r_switch - 3'd1;
      end
    end
  end

  // State register plus the registered outputs/datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_switch <= 3'd0;
      r_down   <= 1'b0;
      r_presc  <= '0;
      r_step   <= 1'b0;
      r_lap    <= 1'b0;
      r_enable <= EN_OFF;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_switch <= w_switch_nxt;
      r_down   <= w_down_nxt;
      r_presc  <= w_presc_nxt;
      r_step   <= w_step_nxt;
      r_lap    <= w_lap_nxt;
      r_enable <= w_enable_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next state: stop beats start beats pause.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.stop) begin
      w_state_nxt = S_IDLE;
    end else if (bus.start) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (bus.pause)  w_state_nxt = S_HOLD;
        S_HOLD:  if (!bus.pause) w_state_nxt = S_RUN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Next values for the registered outputs and scan datapath.
  always_comb begin
    w_switch_nxt = r_switch;
    w_down_nxt   = r_down;
    w_presc_nxt  = r_presc;
    w_step_nxt   = 1'b0;
    w_lap_nxt    = 1'b0;
    w_enable_nxt = (w_state_nxt == S_IDLE) ? EN_OFF : EN_ON;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    if (bus.stop) begin
      // switch keeps its last value so the display can be read back
      w_presc_nxt = '0;
    end else if (bus.start) begin
      w_switch_nxt = bus.dir ? 3'd7 : 3'd0;
      w_down_nxt   = bus.dir;
      w_presc_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: w_presc_nxt = '0;
        S_RUN: begin
          // the cycle that enters HOLD is already frozen
          if (!bus.pause) begin
            if (w_tick) begin
              w_presc_nxt  = '0;
              w_switch_nxt = w_adv_idx;
              w_down_nxt   = w_adv_down;
              w_step_nxt   = 1'b1;
              w_lap_nxt    = w_adv_lap;
            end else begin
              w_presc_nxt = r_presc + PRESCALE_W'(1);
            end
          end
        end
        default: ;  // HOLD: everything frozen
      endcase
    end
  end

  assign bus.switch = r_switch;
  assign bus.enable = r_enable;
  assign bus.busy   = r_busy;
  assign bus.step   = r_step;
  assign bus.lap    = r_lap;

endmodule
